// File: rtl/limber_gnrl_pipe.sv
// limber_gnrl_pipe: DEPTH-stage elastic pipeline register with back-pressure, flush and occupancy count.
// Define LIMBER_GNRL_PIPE_SKID_EN to add a one-entry skid register that makes i_ready registered.
module limber_gnrl_pipe #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DW-1:0]    d_d [DEPTH];
  logic             src0_v;
  logic [DW-1:0]    src0_d;
  logic [CW-1:0]    cnt_stages;

  // Stage k may advance when any stage from k onward is empty or the sink takes the head word.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = o_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!v_q[j]) adv[k] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      v_d[k] = v_q[k];
      d_d[k] = d_q[k];
    end
    if (adv[0]) begin
      v_d[0] = src0_v;
      if (src0_v) d_d[0] = src0_d;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) d_d[k] = d_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q <= flush ? '0 : v_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end

  always_comb begin
    cnt_stages = '0;
    for (int k = 0; k < DEPTH; k++) cnt_stages = cnt_stages + CW'(v_q[k]);
  end

  assign o_valid = v_q[DEPTH-1];
  assign o_data  = d_q[DEPTH-1];

`ifdef LIMBER_GNRL_PIPE_SKID_EN
  logic          skid_v_q;
  logic [DW-1:0] skid_d_q;

  assign i_ready = ~skid_v_q;
  assign src0_v  = skid_v_q | i_valid;
  assign src0_d  = skid_v_q ? skid_d_q : i_data;
  assign count   = cnt_stages + CW'(skid_v_q);

  // A word accepted while stage 0 is blocked parks here; it drains ahead of any new input.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
    end else if (flush) begin
      skid_v_q <= 1'b0;
    end else if (skid_v_q) begin
      if (adv[0]) skid_v_q <= 1'b0;
    end else if (i_valid && !adv[0]) begin
      skid_v_q <= 1'b1;
      skid_d_q <= i_data;
    end
  end
`else
  assign i_ready = adv[0];
  assign src0_v  = i_valid;
  assign src0_d  = i_data;
  assign count   = cnt_stages;
`endif

endmodule

// File: doc/limber_gnrl_pipe.md
Name: limber_gnrl_pipe

Overview:
- Parametrised elastic pipeline register.
- Generalises the single load-enabled DFF into DEPTH chained stages of DW bits, each with a valid bit and valid/ready handshake.
- Supports back-pressure, synchronous flush and an occupancy count.
- Used between MCU datapath units (fetch to decode, LSU response paths) where retiming with stall support is needed.

Parameters:
- DW, 8, data width in bits (>=1)
- DEPTH, 2, number of register stages (>=1)
- CW, $clog2(DEPTH+2), width of the count output

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of all stored entries
- i_valid  input  1  upstream data valid
- i_ready  output  1  pipe can accept i_data this cycle
- i_data  input  DW  upstream data
- o_valid  output  1  last stage holds valid data
- o_ready  input  1  downstream accepts o_data this cycle
- o_data  output  DW  last-stage data
- count  output  CW  number of valid entries held

Behaviour:
- Stage k (0..DEPTH-1) holds v[k] and d[k]. Stage 0 is fed from the input; stage DEPTH-1 drives o_valid/o_data.
- Advance condition:
  - adv[DEPTH-1] = ~v[DEPTH-1] | o_ready
  - adv[k] = ~v[k] | adv[k+1]
  - i_ready = adv[0] (combinational, no bubble insertion).
- Stage k loads when adv[k] is true:
  - v[k] <= source valid (i_valid for k=0, else v[k-1])
  - d[k] <= source data, only when the source is valid; data is held otherwise.
- Handshakes: input transfer = i_valid & i_ready; output transfer = o_valid & o_ready.
- i_data may change freely while i_valid is low.
- Latency: an accepted word appears on o_valid exactly DEPTH cycles later when unstalled. Throughput is 1 word/cycle when o_ready is held high.
- Back-pressure: with o_ready low, bubbles compress. The pipe fills to DEPTH entries, then i_ready drops. No word is lost or duplicated, and order is preserved.
- Full with o_ready=1 and i_valid=1: accept and emit in the same cycle; count is unchanged.
- Empty: o_valid=0; o_data holds the last value.
- count = number of set v[k] (plus the skid entry when enabled). It updates the cycle after a transfer.
- flush=1: all v[k] <= 0 next cycle and count <= 0.
  - A word presented in the flush cycle is dropped, even if i_ready was high.
  - An output transfer in the flush cycle still completes.
- rst=1: all v[k] <= 0 and all d[k] <= 0, giving o_valid=0, o_data=0, count=0 and i_ready=1 the cycle after reset.
  - Reset takes priority over flush and handshakes.
  - Reset mid-stream discards all contents.
- No combinational path from i_valid/i_data to o_valid/o_data.

Optional Feature:
- Macro: LIMBER_GNRL_PIPE_SKID_EN
- Defined:
  - A one-entry skid register sits in front of stage 0.
  - i_ready = ~skid_v is registered, which breaks the o_ready-to-i_ready combinational path.
  - An accepted word goes to stage 0 if adv[0], otherwise into the skid register.
  - While skid_v=1, stage 0 loads from the skid register first.
  - Capacity becomes DEPTH+1; count includes skid_v.
  - Latency when unstalled is still DEPTH.
  - flush and rst clear skid_v.
- Undefined:
  - Behaviour is exactly as in Behaviour above.
  - i_ready is combinational; capacity is DEPTH.

Test Plan:
- DW=8, DEPTH=3, o_ready=1, stream 0x01..0x10 back-to-back -> o_data 0x01 first valid on the 3rd cycle after the first accept, then one word per cycle in order, count steady at 3.
- o_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> i_ready drops after 3 accepts, count=3. Release o_ready -> output 0xA1,0xA2,0xA3, then 0xA4 accepted and output, no loss or duplicates.
- Full pipe, i_valid=1, o_ready=1 continuously for 20 cycles -> one-in/one-out every cycle, count stays 3.
- Pipe holding 2 words, assert flush with i_valid=1 (0x55) -> next cycle o_valid=0, count=0, 0x55 never appears.
- Assert rst mid-stream with 3 words held -> next cycle o_valid=0, o_data=0x00, count=0, i_ready=1. Subsequent stream is correct.
- With LIMBER_GNRL_PIPE_SKID_EN, DEPTH=2, o_ready=0 -> 3 words accepted, i_ready=0 registered, count=3. Toggle o_ready randomly for 200 cycles -> scoreboard order and content match.
